// File: rtl/wf_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// wf_ctrl_pkg
// Shared definitions for the multi-channel waveform register block:
//   - register word indices (fixed part of the map)
//   - AXI response codes
//   - read_cnt_base(): first READ_CNT word index for a given channel count
//   - strb_merge():    byte-lane merge of a write into an existing value
// ----------------------------------------------------------------------------
package wf_ctrl_pkg;

    localparam int unsigned IDX_CTRL         = 0;
    localparam int unsigned IDX_WF_SEL       = 1;
    localparam int unsigned IDX_WF_ADDR      = 2;
    localparam int unsigned IDX_WF_DATA      = 3;
    localparam int unsigned IDX_MAX_CNT_BASE = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // READ_CNT words follow the NUM_CH MAX_CNT words.
    function automatic int unsigned read_cnt_base(input int unsigned num_ch);
        return IDX_MAX_CNT_BASE + num_ch;
    endfunction

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wf_load_port.sv
// ----------------------------------------------------------------------------
// wf_load_port
// Holds the load-channel select (WF_SEL) and the auto-incrementing load
// address (WF_ADDR), and turns a WF_DATA commit into a one-cycle, one-hot
// DPBRAM write pulse.
// Ports:
//   clk_i, srst_i         clock, synchronous active-high reset
//   sel_we_i, addr_we_i   commit strobes for WF_SEL / WF_ADDR writes
//   load_i                commit strobe for a WF_DATA write
//   wdata_i, wstrb_i      committed write data / byte strobes
//   sel_rd_o, addr_rd_o   read-back values (zero-extended)
//   err_o                 combinational: load_i with an out-of-range select
//   write_en_o/addr_o/data_o  DPBRAM write port (registered)
// ----------------------------------------------------------------------------
module wf_load_port
    import wf_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int WF_ADDR_WIDTH = 10,
    parameter int WF_DATA_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     sel_we_i,
    input  logic                     addr_we_i,
    input  logic                     load_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               wstrb_i,
    output logic [31:0]              sel_rd_o,
    output logic [31:0]              addr_rd_o,
    output logic                     err_o,
    output logic [NUM_CH-1:0]        write_en_o,
    output logic [WF_ADDR_WIDTH-1:0] write_addr_o,
    output logic [WF_DATA_WIDTH-1:0] write_data_o
);

    localparam int          SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] NUM_CH_W = 32'(NUM_CH);

    logic [SEL_W-1:0]         sel_q, sel_d;
    // Only the low SEL_W bits are stored, but a written value that does not
    // name a real channel must still make later loads fail; remember that.
    logic                     sel_bad_q, sel_bad_d;
    logic [WF_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_CH-1:0]        we_q, we_d;
    logic [WF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WF_DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [31:0] sel_ext, addr_ext, sel_merged, addr_merged;
    logic        sel_valid, do_load;

    assign sel_ext     = 32'(sel_q);
    assign addr_ext    = 32'(addr_q);
    assign sel_merged  = strb_merge(sel_ext, wdata_i, wstrb_i);
    assign addr_merged = strb_merge(addr_ext, wdata_i, wstrb_i);

    assign sel_valid = !sel_bad_q && (sel_ext < NUM_CH_W);
    assign err_o     = load_i && !sel_valid;
    assign do_load   = load_i && sel_valid && (|wstrb_i);

    always_comb begin
        sel_d     = sel_q;
        sel_bad_d = sel_bad_q;
        addr_d    = addr_q;
        we_d      = '0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;

        if (sel_we_i && (|wstrb_i)) begin
            sel_d     = sel_merged[SEL_W-1:0];
            sel_bad_d = (sel_merged >= NUM_CH_W);
        end

        if (addr_we_i) begin
            addr_d = addr_merged[WF_ADDR_WIDTH-1:0];
        end

        if (do_load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                we_d[k] = (sel_ext == 32'(k));
            end
            waddr_d = addr_q;
            wdata_d = wdata_i[WF_DATA_WIDTH-1:0];
            addr_d  = addr_q + 1'b1;    // natural wrap at 2^WF_ADDR_WIDTH
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            sel_q     <= '0;
            sel_bad_q <= 1'b0;
            addr_q    <= '0;
            we_q      <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            sel_q     <= sel_d;
            sel_bad_q <= sel_bad_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign sel_rd_o     = sel_ext;
    assign addr_rd_o    = addr_ext;
    assign write_en_o   = we_q;
    assign write_addr_o = waddr_q;
    assign write_data_o = wdata_q;

    logic unused_bits;
    assign unused_bits = ^{addr_merged[31:WF_ADDR_WIDTH > 31 ? 31 : WF_ADDR_WIDTH]};

endmodule

// File: rtl/axi4_lite_wf_ctrl.sv
// ----------------------------------------------------------------------------
// axi4_lite_wf_ctrl
// AXI4-Lite register slave for NUM_CH waveform channels.
// Word map: 0 CTRL, 1 WF_SEL, 2 WF_ADDR, 3 WF_DATA (load trigger),
//           4+k MAX_CNT[k], 4+NUM_CH+k READ_CNT[k] (read-only).
// Ports:
//   S_AXI_ACLK / S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_*                     AXI4-Lite slave (PROT ignored)
//   o_wf_mode_start             per-channel run level (CTRL bits)
//   o_wf_write_en/addr/data     DPBRAM load port, one-hot one-cycle pulse
//   o_wf_max_cnt                per-channel max count, 32 bits per channel
//   i_wf_read_cnt               per-channel playback counters
// ----------------------------------------------------------------------------
module axi4_lite_wf_ctrl
    import wf_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH             = 2,
    parameter int WF_ADDR_WIDTH      = 10,
    parameter int WF_DATA_WIDTH      = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_CH-1:0]               o_wf_mode_start,
    output logic [NUM_CH-1:0]               o_wf_write_en,
    output logic [WF_ADDR_WIDTH-1:0]        o_wf_write_addr,
    output logic [WF_DATA_WIDTH-1:0]        o_wf_write_data,
    output logic [32*NUM_CH-1:0]            o_wf_max_cnt,
    input  logic [32*NUM_CH-1:0]            i_wf_read_cnt
);

    localparam int          AW      = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned RC_BASE = read_cnt_base(NUM_CH);
    localparam int unsigned END_IDX = RC_BASE + NUM_CH;

    logic clk, srst;
    assign clk  = S_AXI_ACLK;
    assign srst = S_AXI_ARESET;

    // ---------------- write channel ----------------
    logic          aw_full_q, w_full_q, bvalid_q;
    logic [AW-3:0] aw_word_q;
    logic [31:0]   w_data_q;
    logic [3:0]    w_strb_q;
    logic [1:0]    bresp_q, bresp_d;
    logic          aw_ready, w_ready, commit;
    logic [31:0]   wr_idx;

    assign aw_ready = !srst && !aw_full_q && !bvalid_q;
    assign w_ready  = !srst && !w_full_q && !bvalid_q;
    // Slots stay full while BVALID is up, so !bvalid_q keeps this to one cycle.
    assign commit   = aw_full_q && w_full_q && !bvalid_q;
    assign wr_idx   = 32'(aw_word_q);

    logic              wr_ctrl, wr_sel, wr_waddr, wr_load, wr_bad, load_err;
    logic [NUM_CH-1:0] wr_max;

    always_comb begin
        wr_ctrl  = 1'b0;
        wr_sel   = 1'b0;
        wr_waddr = 1'b0;
        wr_load  = 1'b0;
        wr_bad   = 1'b0;
        wr_max   = '0;
        if (commit) begin
            if (wr_idx == IDX_CTRL) begin
                wr_ctrl = 1'b1;
            end else if (wr_idx == IDX_WF_SEL) begin
                wr_sel = 1'b1;
            end else if (wr_idx == IDX_WF_ADDR) begin
                wr_waddr = 1'b1;
            end else if (wr_idx == IDX_WF_DATA) begin
                wr_load = 1'b1;
            end else if (wr_idx >= IDX_MAX_CNT_BASE && wr_idx < RC_BASE) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    wr_max[k] = (wr_idx == IDX_MAX_CNT_BASE + k);
                end
            end else begin
                wr_bad = 1'b1;   // READ_CNT words or beyond the map
            end
        end
    end

    assign bresp_d = (wr_bad || load_err) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clk) begin
        if (srst) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_word_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_ready && S_AXI_AWVALID) begin
                aw_full_q <= 1'b1;
                aw_word_q <= S_AXI_AWADDR[AW-1:2];
            end
            if (w_ready && S_AXI_WVALID) begin
                w_full_q <= 1'b1;
                w_data_q <= S_AXI_WDATA[31:0];
                w_strb_q <= S_AXI_WSTRB[3:0];
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= bresp_d;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q  <= 1'b0;
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
            end
        end
    end

    // ---------------- register file ----------------
    logic [NUM_CH-1:0]       ctrl_q;
    logic [31:0]             ctrl_merged;
    logic [NUM_CH-1:0][31:0] max_cnt_q;

    assign ctrl_merged = strb_merge(32'(ctrl_q), w_data_q, w_strb_q);

    always_ff @(posedge clk) begin
        if (srst) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= ctrl_merged[NUM_CH-1:0];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_max_cnt
            always_ff @(posedge clk) begin
                if (srst) begin
                    max_cnt_q[gi] <= '0;
                end else if (wr_max[gi]) begin
                    max_cnt_q[gi] <= strb_merge(max_cnt_q[gi], w_data_q, w_strb_q);
                end
            end
        end
    endgenerate

    logic [31:0] sel_rd, addr_rd;

    wf_load_port #(
        .NUM_CH        (NUM_CH),
        .WF_ADDR_WIDTH (WF_ADDR_WIDTH),
        .WF_DATA_WIDTH (WF_DATA_WIDTH)
    ) u_load_port (
        .clk_i        (clk),
        .srst_i       (srst),
        .sel_we_i     (wr_sel),
        .addr_we_i    (wr_waddr),
        .load_i       (wr_load),
        .wdata_i      (w_data_q),
        .wstrb_i      (w_strb_q),
        .sel_rd_o     (sel_rd),
        .addr_rd_o    (addr_rd),
        .err_o        (load_err),
        .write_en_o   (o_wf_write_en),
        .write_addr_o (o_wf_write_addr),
        .write_data_o (o_wf_write_data)
    );

    // ---------------- read channel ----------------
    logic        rvalid_q, ar_ready;
    logic [31:0] rdata_q, rd_data_d, rd_idx;
    logic [1:0]  rresp_q, rd_resp_d;

    assign ar_ready = !srst && !rvalid_q;
    assign rd_idx   = 32'(S_AXI_ARADDR[AW-1:2]);

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        if (rd_idx == IDX_CTRL) begin
            rd_data_d = 32'(ctrl_q);
        end else if (rd_idx == IDX_WF_SEL) begin
            rd_data_d = sel_rd;
        end else if (rd_idx == IDX_WF_ADDR) begin
            rd_data_d = addr_rd;
        end else if (rd_idx == IDX_WF_DATA) begin
            rd_data_d = '0;     // write-only trigger reads as zero
        end else if (rd_idx >= IDX_MAX_CNT_BASE && rd_idx < RC_BASE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_idx == IDX_MAX_CNT_BASE + k) begin
                    rd_data_d = max_cnt_q[k];
                end
            end
        end else if (rd_idx >= RC_BASE && rd_idx < END_IDX) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (rd_idx == RC_BASE + k) begin
                    rd_data_d = i_wf_read_cnt[32*k +: 32];
                end
            end
        end else begin
            rd_resp_d = RESP_SLVERR;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_ready && S_AXI_ARVALID) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign S_AXI_AWREADY   = aw_ready;
    assign S_AXI_WREADY    = w_ready;
    assign S_AXI_BVALID    = bvalid_q;
    assign S_AXI_BRESP     = bresp_q;
    assign S_AXI_ARREADY   = ar_ready;
    assign S_AXI_RVALID    = rvalid_q;
    assign S_AXI_RRESP     = rresp_q;
    assign S_AXI_RDATA     = C_S_AXI_DATA_WIDTH'(rdata_q);
    assign o_wf_mode_start = ctrl_q;
    assign o_wf_max_cnt    = max_cnt_q;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                             S_AXI_ARADDR[1:0], ctrl_merged};

endmodule

// File: tb/tb_axi4_lite_wf_ctrl.sv
module tb_axi4_lite_wf_ctrl;

    logic        clk = 1'b0;
    logic        srst;
    logic [5:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [5:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [1:0]  mode_start;
    logic [1:0]  write_en;
    logic [9:0]  write_addr;
    logic [15:0] write_data;
    logic [63:0] max_cnt;
    logic [63:0] read_cnt;

    always #5 clk = ~clk;

    axi4_lite_wf_ctrl #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .NUM_CH             (2),
        .WF_ADDR_WIDTH      (10),
        .WF_DATA_WIDTH      (16)
    ) dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESET    (srst),
        .S_AXI_AWADDR    (awaddr),
        .S_AXI_AWPROT    (awprot),
        .S_AXI_AWVALID   (awvalid),
        .S_AXI_AWREADY   (awready),
        .S_AXI_WDATA     (wdata),
        .S_AXI_WSTRB     (wstrb),
        .S_AXI_WVALID    (wvalid),
        .S_AXI_WREADY    (wready),
        .S_AXI_BRESP     (bresp),
        .S_AXI_BVALID    (bvalid),
        .S_AXI_BREADY    (bready),
        .S_AXI_ARADDR    (araddr),
        .S_AXI_ARPROT    (arprot),
        .S_AXI_ARVALID   (arvalid),
        .S_AXI_ARREADY   (arready),
        .S_AXI_RDATA     (rdata),
        .S_AXI_RRESP     (rresp),
        .S_AXI_RVALID    (rvalid),
        .S_AXI_RREADY    (rready),
        .o_wf_mode_start (mode_start),
        .o_wf_write_en   (write_en),
        .o_wf_write_addr (write_addr),
        .o_wf_write_data (write_data),
        .o_wf_max_cnt    (max_cnt),
        .i_wf_read_cnt   (read_cnt)
    );

    // Every DPBRAM write pulse, sampled mid-cycle.
    typedef struct {
        logic [1:0]  en;
        logic [9:0]  addr;
        logic [15:0] data;
    } pulse_t;
    pulse_t pq[$];

    always @(negedge clk) begin
        if (|write_en) begin
            pq.push_back('{en: write_en, addr: write_addr, data: write_data});
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Called in the posedge+1 phase; returns in the same phase.
    task automatic axi_write(input logic [3:0] idx, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        int   n;
        logic aw_hs, w_hs;
        awaddr = {idx, 2'b00}; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs)  wvalid  = 1'b0;
            n++;
        end
        while (!bvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bvalid) begin
            timeout("axi_write");
            resp = 2'bxx;
            awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            resp = bresp;
            @(posedge clk); #1;
        end
        bready = 1'b0;
        $display("write idx %0d data %h strb %b -> bresp %b", idx, d, s, resp);
    endtask

    task automatic axi_read(input logic [3:0] idx, output logic [31:0] d,
                            output logic [1:0] resp);
        int   n;
        logic ar_hs;
        araddr = {idx, 2'b00}; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            ar_hs = arready;
            @(posedge clk); #1;
            if (ar_hs) arvalid = 1'b0;
            n++;
        end
        while (!rvalid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rvalid) begin
            timeout("axi_read");
            d = 'x; resp = 2'bxx;
            arvalid = 1'b0;
        end else begin
            d = rdata; resp = rresp;
            @(posedge clk); #1;
        end
        rready = 1'b0;
        $display("read  idx %0d -> rdata %h rresp %b", idx, d, resp);
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  idx;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;

    vec_t        vecs[22];
    logic [31:0] rd;
    logic [1:0]  rsp;
    int          base;
    int          n;

    initial begin
        // ---- vector table: register map after reset, then basic RW ----
        vecs[0]  = '{1'b0, 4'd0,  32'h0,        4'h0, OK,  32'h0};
        vecs[1]  = '{1'b0, 4'd1,  32'h0,        4'h0, OK,  32'h0};
        vecs[2]  = '{1'b0, 4'd2,  32'h0,        4'h0, OK,  32'h0};
        vecs[3]  = '{1'b0, 4'd3,  32'h0,        4'h0, OK,  32'h0};
        vecs[4]  = '{1'b0, 4'd4,  32'h0,        4'h0, OK,  32'h0};
        vecs[5]  = '{1'b0, 4'd5,  32'h0,        4'h0, OK,  32'h0};
        vecs[6]  = '{1'b0, 4'd6,  32'h0,        4'h0, OK,  32'h0000_0055};
        vecs[7]  = '{1'b0, 4'd7,  32'h0,        4'h0, OK,  32'h0000_1234};
        vecs[8]  = '{1'b0, 4'd8,  32'h0,        4'h0, ERR, 32'h0};
        vecs[9]  = '{1'b0, 4'd15, 32'h0,        4'h0, ERR, 32'h0};
        vecs[10] = '{1'b1, 4'd0,  32'h0000_0003, 4'hF, OK,  32'h0};
        vecs[11] = '{1'b0, 4'd0,  32'h0,        4'h0, OK,  32'h0000_0003};
        vecs[12] = '{1'b1, 4'd4,  32'hDEAD_BEEF, 4'hF, OK,  32'h0};
        vecs[13] = '{1'b0, 4'd4,  32'h0,        4'h0, OK,  32'hDEAD_BEEF};
        vecs[14] = '{1'b1, 4'd4,  32'h1122_3344, 4'b0010, OK, 32'h0};
        vecs[15] = '{1'b0, 4'd4,  32'h0,        4'h0, OK,  32'hDEAD_33EF};
        vecs[16] = '{1'b1, 4'd6,  32'hFFFF_FFFF, 4'hF, ERR, 32'h0};
        vecs[17] = '{1'b0, 4'd6,  32'h0,        4'h0, OK,  32'h0000_0055};
        vecs[18] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 4'hF, ERR, 32'h0};
        vecs[19] = '{1'b1, 4'd0,  32'hFFFF_FFFF, 4'hF, OK,  32'h0};
        vecs[20] = '{1'b0, 4'd0,  32'h0,        4'h0, OK,  32'h0000_0003};
        vecs[21] = '{1'b0, 4'd5,  32'h0,        4'h0, OK,  32'h0};

        srst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        read_cnt = {32'h0000_1234, 32'h0000_0055};

        repeat (3) @(posedge clk);
        #1;
        check("rst_bvalid",  32'(bvalid), 32'h0);
        check("rst_rvalid",  32'(rvalid), 32'h0);
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_mode",    32'(mode_start), 32'h0);
        check("rst_maxcnt",  max_cnt[31:0] | max_cnt[63:32], 32'h0);
        check("rst_we",      32'(write_en), 32'h0);
        srst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 22; i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].idx, vecs[i].data, vecs[i].strb, rsp);
                check($sformatf("vec%0d_bresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].idx, rd, rsp);
                check($sformatf("vec%0d_rresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end
        check("mode_start_out", 32'(mode_start), 32'h3);
        check("no_pulse_yet", 32'(pq.size()), 32'h0);

        // ---- DPBRAM load with address wrap ----
        axi_write(4'd1, 32'h1, 4'hF, rsp);
        axi_write(4'd2, 32'h3FE, 4'hF, rsp);
        base = pq.size();
        axi_write(4'd3, 32'hA, 4'hF, rsp);
        check("load0_bresp", 32'(rsp), 32'(OK));
        axi_write(4'd3, 32'hB, 4'hF, rsp);
        axi_write(4'd3, 32'hC, 4'hF, rsp);
        check("load_pulse_cnt", 32'(pq.size() - base), 32'd3);
        if (pq.size() - base == 3) begin
            check("load0_en",   32'(pq[base].en),     32'h2);
            check("load0_addr", 32'(pq[base].addr),   32'h3FE);
            check("load0_data", 32'(pq[base].data),   32'hA);
            check("load1_addr", 32'(pq[base+1].addr), 32'h3FF);
            check("load1_data", 32'(pq[base+1].data), 32'hB);
            check("load2_en",   32'(pq[base+2].en),   32'h2);
            check("load2_addr", 32'(pq[base+2].addr), 32'h000);
            check("load2_data", 32'(pq[base+2].data), 32'hC);
        end
        check("load_hold_addr", 32'(write_addr), 32'h000);
        check("load_hold_data", 32'(write_data), 32'hC);
        axi_read(4'd2, rd, rsp);
        check("wf_addr_after", rd, 32'h1);

        // WSTRB=0 load: OKAY, no pulse, no increment
        base = pq.size();
        axi_write(4'd3, 32'hD, 4'h0, rsp);
        check("load_nostrb_bresp", 32'(rsp), 32'(OK));
        check("load_nostrb_pulse", 32'(pq.size() - base), 32'h0);
        axi_read(4'd2, rd, rsp);
        check("load_nostrb_addr", rd, 32'h1);

        // ---- W ahead of AW, BREADY held low ----
        wdata = 32'h5A5A; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("early_w_taken", 32'(wready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("early_w_nob%0d", i), 32'(bvalid), 32'h0);
            @(posedge clk); #1;
        end
        check("early_w_nocommit", max_cnt[63:32], 32'h0);
        awaddr = {4'd5, 2'b00}; awvalid = 1'b1;
        check("early_awready", 32'(awready), 32'h1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("aw_hs_bvalid0", 32'(bvalid), 32'h0);
        @(posedge clk); #1;
        check("aw_hs_bvalid1", 32'(bvalid), 32'h1);
        check("aw_hs_bresp", 32'(bresp), 32'(OK));
        check("aw_hs_maxcnt1", max_cnt[63:32], 32'h5A5A);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bhold_bvalid%0d", i), 32'(bvalid), 32'h1);
            check($sformatf("bhold_awready%0d", i), 32'(awready), 32'h0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("b_done_bvalid", 32'(bvalid), 32'h0);
        check("b_done_awready", 32'(awready), 32'h1);
        $display("early-W write idx 5 data 00005a5a completed");

        // ---- partial strobe over zero ----
        axi_write(4'd4, 32'h0, 4'hF, rsp);
        axi_write(4'd4, 32'hFFFF_FFFF, 4'b0101, rsp);
        check("strb0101_bresp", 32'(rsp), 32'(OK));
        check("strb0101_maxcnt0", max_cnt[31:0], 32'h00FF_00FF);

        // ---- out-of-range load channel ----
        axi_write(4'd1, 32'h3, 4'hF, rsp);
        base = pq.size();
        axi_write(4'd3, 32'hE, 4'hF, rsp);
        check("badsel_bresp", 32'(rsp), 32'(ERR));
        check("badsel_pulse", 32'(pq.size() - base), 32'h0);
        axi_read(4'd2, rd, rsp);
        check("badsel_addr", rd, 32'h1);

        // ---- reset with BVALID and RVALID pending ----
        axi_write(4'd1, 32'h0, 4'hF, rsp);
        awaddr = {4'd3, 2'b00}; awvalid = 1'b1;
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        araddr = {4'd7, 2'b00}; arvalid = 1'b1; rready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n = 0;
        while (!(bvalid && rvalid) && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(bvalid && rvalid)) timeout("pend_valid");
        @(posedge clk); #1;
        check("pend_bvalid", 32'(bvalid), 32'h1);
        check("pend_rvalid", 32'(rvalid), 32'h1);
        base = pq.size();
        srst = 1'b1;
        @(posedge clk); #1;
        check("rst2_bvalid", 32'(bvalid), 32'h0);
        check("rst2_rvalid", 32'(rvalid), 32'h0);
        check("rst2_mode", 32'(mode_start), 32'h0);
        check("rst2_maxcnt0", max_cnt[31:0], 32'h0);
        check("rst2_maxcnt1", max_cnt[63:32], 32'h0);
        check("rst2_waddr", 32'(write_addr), 32'h0);
        check("rst2_wdata", 32'(write_data), 32'h0);
        @(posedge clk); #1;
        srst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst2_no_pulse", 32'(pq.size() - base), 32'h0);
        check("rst2_bvalid_after", 32'(bvalid), 32'h0);
        axi_read(4'd2, rd, rsp);
        check("rst2_wf_addr", rd, 32'h0);
        $display("reset-with-pending sequence completed");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
